elevator_scan: RTL and testbench
================================

ELEVATOR_SCAN -- requirements
Module: elevator_scan

Parameters
REQ-001 FLOORS, default 4: number of served floors, legal range 2..16.
REQ-002 DOOR_HOLD, default 2: number of cycles the door stays open per stop, legal range 1..15.
REQ-003 POS_W, default $clog2(2*FLOORS-1): width of the position output.

Interface
REQ-004 clk  in  1  single system clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 button_up  in  FLOORS-1  hall-up call; bit i is floor i (0-based floors 0..FLOORS-2).
REQ-007 button_down  in  FLOORS-1  hall-down call; bit i is floor i+1.
REQ-008 button_in  in  FLOORS  cabin call; bit i is floor i.
REQ-009 position  out  POS_W  2*f when at floor f; 2*f+1 when between floors f and f+1.
REQ-010 open  out  1  0 = door closed, 1 = door open.
REQ-011 direction  out  2  00 = stop, 01 = up, 10 = down; 11 never driven.
REQ-012 pending  out  1  OR of all latched requests.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 A button bit sampled high at a rising edge SHALL set its request latch at that edge; buttons are pulse-tolerant, and level-held inputs are equivalent to a single pulse.
REQ-015 Scheduling SHALL use only latched requests, so a press sampled at edge k is first acted on at edge k+1.
REQ-016 The FSM SHALL have exactly four states: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
REQ-017 IDLE (direction 00, open 0), in priority order:
  - request at the current floor -> DOOR_OPEN;
  - else any request above -> MOVE_UP;
  - else any request below -> MOVE_DOWN;
  - above-before-below on tie.
REQ-018 MOVE_UP / MOVE_DOWN: position SHALL change by +1 / -1 per cycle; direction is 01 / 10.
REQ-019 On reaching an even position while moving up, the car SHALL stop (-> DOOR_OPEN) if either:
  - a cabin or up request is latched at that floor; or
  - no request is latched above and a down request is latched here.
  MOVE_DOWN mirrors this rule.
REQ-020 Position SHALL never leave 0..2*(FLOORS-1); the top and bottom floors always stop.
REQ-021 DOOR_OPEN SHALL assert open=1 for exactly DOOR_HOLD cycles.
  - Position is held.
  - direction keeps the service direction, or 00 if entered from IDLE with nothing else pending.
REQ-022 On entering DOOR_OPEN, the latches cleared SHALL be:
  - the cabin latch at that floor;
  - the hall latch matching the service direction;
  - in IDLE entry, both hall latches at that floor.
REQ-023 A new matching request at the open floor while in DOOR_OPEN SHALL reload the hold counter to DOOR_HOLD and not be latched.
REQ-024 On door close, the next state SHALL be:
  - continue in the current direction if requests remain ahead;
  - else reverse if requests remain behind;
  - else IDLE.
  The door SHALL close for at least one cycle before motion.
REQ-025 Simultaneous set and clear of the same latch SHALL resolve as clear; the request is already served.

Reset
REQ-026 While reset is sampled high, the next edge SHALL give: position 0, open 0, direction 00, pending 0, all latches clear, state IDLE, hold counter 0.
REQ-027 Reset SHALL override any in-progress motion or door cycle, including a between-floor position.

Structure
REQ-028 A shared package elevator_pkg SHALL hold:
  - the state enum;
  - DIR_STOP / DIR_UP / DIR_DOWN constants;
  - position-width helper function.
REQ-029 Request latching and clearing SHALL be in one sub-module, elevator_req_reg, parametrised by FLOORS, exporting:
  - per-floor latched vectors;
  - any_above(floor) / any_below(floor) reductions.

Verification (FLOORS=4, DOOR_HOLD=2 unless noted)
REQ-030 Reset -> position 0, open 0, direction 00, pending 0 on the next edge.
REQ-031 Idle at 0, pulse button_in[3] -> IDLE for 1 cycle, direction 01, then:
  - position 1,2,3,4,5,6;
  - open=1 for 2 cycles at 6;
  - then direction 00, pending 0.
REQ-032 Car moving up at position 1 toward cabin call 3, pulse button_down[1] (floor 2) -> passes position 4 without stopping, opens at 6, reverses, opens at 4 with direction 10.
REQ-033 Door open at floor 1 serving up, pulse button_up[1] on the 2nd open cycle -> open extended to 3 total cycles, latch not set.
REQ-034 Reset asserted while position=3 and moving -> position 0, direction 00, all latches clear on the next edge.
REQ-035 FLOORS=6, pulse button_in[5] from floor 0 -> stops at position 10 and never emits 11.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and constants for the SCAN elevator controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package elevator_pkg;

    // Controller states. Exactly these four are used.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_e;

    // Encoding of the direction output. 2'b11 is never driven.
    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    // Width of the door hold counter. It must hold DOOR_HOLD values up to 15.
    localparam int HOLD_W = 4;

    // Position counts half-floors: 0 .. 2*(floors-1).
    function automatic int pos_width(input int floors);
        return $clog2(2 * floors - 1);
    endfunction

endpackage

// File: rtl/elevator_req_reg.sv
// Request latches for hall-up, hall-down and cabin calls, with above/below reductions per floor.
// Latency: a button sampled at edge k shows in the latched vectors after edge k; clears apply at the same edge.
// Backpressure: none; button inputs are pulse-tolerant, and a clear wins over a set at the same edge.
module elevator_req_reg
    import elevator_pkg::*;
#(
    parameter int FLOORS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-2:0] set_up_i,     // bit i = floor i
    input  logic [FLOORS-2:0] set_dn_i,     // bit i = floor i+1
    input  logic [FLOORS-1:0] set_cab_i,    // bit i = floor i
    input  logic [FLOORS-1:0] clr_up_i,     // per-floor clear strobes
    input  logic [FLOORS-1:0] clr_dn_i,
    input  logic [FLOORS-1:0] clr_cab_i,
    output logic [FLOORS-1:0] up_o,         // per-floor latched vectors
    output logic [FLOORS-1:0] dn_o,
    output logic [FLOORS-1:0] cab_o,
    output logic [FLOORS-1:0] any_above_o,  // bit f: some request latched above floor f
    output logic [FLOORS-1:0] any_below_o,  // bit f: some request latched below floor f
    output logic              pending_o
);

    logic [FLOORS-1:0] up_q, up_d;
    logic [FLOORS-1:0] dn_q, dn_d;
    logic [FLOORS-1:0] cab_q, cab_d;
    logic [FLOORS-1:0] req_f;
    logic              pending_q;

    // Next latch values: OR in new presses, then mask with clears so a clear wins.
    // Hall vectors are widened to per-floor form; the top has no up call, the bottom no down call.
    always_comb begin
        up_d  = (up_q  | {1'b0, set_up_i}) & ~clr_up_i;
        dn_d  = (dn_q  | {set_dn_i, 1'b0}) & ~clr_dn_i;
        cab_d = (cab_q | set_cab_i)        & ~clr_cab_i;
    end

    // Latch registers; pending is registered from the next-state so it tracks the latches exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            up_q      <= '0;
            dn_q      <= '0;
            cab_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            up_q      <= up_d;
            dn_q      <= dn_d;
            cab_q     <= cab_d;
            pending_q <= |(up_d | dn_d | cab_d);
        end
    end

    // Per-floor reductions over the latched requests of every other floor.
    always_comb begin
        req_f       = up_q | dn_q | cab_q;
        any_above_o = '0;
        any_below_o = '0;
        for (int f = 0; f < FLOORS; f++) begin
            for (int g = 0; g < FLOORS; g++) begin
                if (g > f) any_above_o[f] = any_above_o[f] | req_f[g];
                if (g < f) any_below_o[f] = any_below_o[f] | req_f[g];
            end
        end
    end

    assign up_o      = up_q;
    assign dn_o      = dn_q;
    assign cab_o     = cab_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/elevator_scan.sv
// SCAN elevator controller: moves one half-floor per cycle, stops for calls in its travel direction, then reverses.
// Latency: a press sampled at edge k is scheduled from edge k+1; all outputs are registered.
// Backpressure: none; a matching call at the open floor extends the door instead of being latched.
module elevator_scan
    import elevator_pkg::*;
#(
    parameter int FLOORS    = 4,
    parameter int DOOR_HOLD = 2,
    parameter int POS_W     = pos_width(FLOORS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-2:0] button_up,
    input  logic [FLOORS-2:0] button_down,
    input  logic [FLOORS-1:0] button_in,
    output logic [POS_W-1:0]  position,
    output logic              open,
    output logic [1:0]        direction,
    output logic              pending
);

    localparam int                FL_W      = $clog2(FLOORS);
    localparam logic [FL_W-1:0]   TOP_FLOOR = FL_W'(FLOORS - 1);
    localparam logic [FL_W-1:0]   BOT_FLOOR = '0;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(DOOR_HOLD);

    state_e              state_q, state_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [1:0]          dir_q, dir_d;
    logic                open_q, open_d;
    logic [1:0]          svc_dir;

    logic [FLOORS-1:0]   req_up, req_dn, req_cab;
    logic [FLOORS-1:0]   any_above, any_below;
    logic [FLOORS-1:0]   clr_up, clr_dn, clr_cab;
    logic [FLOORS-1:0]   btn_up_f, btn_dn_f;

    logic [POS_W-1:0]    pos_up, pos_dn;
    logic [FL_W-1:0]     cur_floor, floor_up, floor_dn;
    logic                door_match;

    elevator_req_reg #(
        .FLOORS (FLOORS)
    ) u_req (
        .clk         (clk),
        .reset       (reset),
        .set_up_i    (button_up),
        .set_dn_i    (button_down),
        .set_cab_i   (button_in),
        .clr_up_i    (clr_up),
        .clr_dn_i    (clr_dn),
        .clr_cab_i   (clr_cab),
        .up_o        (req_up),
        .dn_o        (req_dn),
        .cab_o       (req_cab),
        .any_above_o (any_above),
        .any_below_o (any_below),
        .pending_o   (pending)
    );

    // Candidate positions one step either way and the floors they land on (valid when even).
    assign pos_up    = pos_q + 1'b1;
    assign pos_dn    = pos_q - 1'b1;
    assign cur_floor = FL_W'(pos_q  >> 1);
    assign floor_up  = FL_W'(pos_up >> 1);
    assign floor_dn  = FL_W'(pos_dn >> 1);

    // Raw hall buttons in per-floor form, used to recognise a repeat call at the open floor.
    assign btn_up_f   = {1'b0, button_up};
    assign btn_dn_f   = {button_down, 1'b0};
    assign door_match = button_in[cur_floor]
                      | ((dir_q != DIR_DOWN) & btn_up_f[cur_floor])
                      | ((dir_q != DIR_UP)   & btn_dn_f[cur_floor]);

    // State register together with the registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pos_q   <= '0;
            hold_q  <= '0;
            dir_q   <= DIR_STOP;
            open_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            hold_q  <= hold_d;
            dir_q   <= dir_d;
            open_q  <= open_d;
        end
    end

    // Next state, position, hold count, service direction and latch clears.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        hold_d  = hold_q;
        svc_dir = dir_q;
        clr_up  = '0;
        clr_dn  = '0;
        clr_cab = '0;
        case (state_q)
            IDLE: begin
                if (req_cab[cur_floor] | req_up[cur_floor] | req_dn[cur_floor]) begin
                    // Serve the current floor first; it has no direction yet so both halls go.
                    state_d            = DOOR_OPEN;
                    hold_d             = HOLD_INIT;
                    clr_cab[cur_floor] = 1'b1;
                    clr_up[cur_floor]  = 1'b1;
                    clr_dn[cur_floor]  = 1'b1;
                    if (any_above[cur_floor])      svc_dir = DIR_UP;
                    else if (any_below[cur_floor]) svc_dir = DIR_DOWN;
                    else                           svc_dir = DIR_STOP;
                end else if (any_above[cur_floor]) begin
                    state_d = MOVE_UP;
                end else if (any_below[cur_floor]) begin
                    state_d = MOVE_DOWN;
                end
            end
            MOVE_UP: begin
                pos_d = pos_up;
                if (!pos_up[0] && (req_cab[floor_up] | req_up[floor_up]
                                   | (!any_above[floor_up] & req_dn[floor_up])
                                   | (floor_up == TOP_FLOOR))) begin
                    state_d           = DOOR_OPEN;
                    hold_d            = HOLD_INIT;
                    clr_cab[floor_up] = 1'b1;
                    // Nothing further up and a down call here: the car turns around at this stop.
                    if (any_above[floor_up] | !req_dn[floor_up]) begin
                        svc_dir          = DIR_UP;
                        clr_up[floor_up] = 1'b1;
                    end else begin
                        svc_dir          = DIR_DOWN;
                        clr_dn[floor_up] = 1'b1;
                    end
                end
            end
            MOVE_DOWN: begin
                pos_d = pos_dn;
                if (!pos_dn[0] && (req_cab[floor_dn] | req_dn[floor_dn]
                                   | (!any_below[floor_dn] & req_up[floor_dn])
                                   | (floor_dn == BOT_FLOOR))) begin
                    state_d           = DOOR_OPEN;
                    hold_d            = HOLD_INIT;
                    clr_cab[floor_dn] = 1'b1;
                    if (any_below[floor_dn] | !req_up[floor_dn]) begin
                        svc_dir          = DIR_DOWN;
                        clr_dn[floor_dn] = 1'b1;
                    end else begin
                        svc_dir          = DIR_UP;
                        clr_up[floor_dn] = 1'b1;
                    end
                end
            end
            DOOR_OPEN: begin
                // Calls matching the open door are absorbed rather than latched.
                clr_cab[cur_floor] = 1'b1;
                if (dir_q != DIR_DOWN) clr_up[cur_floor] = 1'b1;
                if (dir_q != DIR_UP)   clr_dn[cur_floor] = 1'b1;
                if (door_match) begin
                    hold_d = HOLD_INIT;
                end else if (hold_q > 4'd1) begin
                    hold_d = hold_q - 1'b1;
                end else begin
                    // Door closes; any motion starts from the following cycle.
                    hold_d = '0;
                    if (dir_q == DIR_DOWN) begin
                        if (any_below[cur_floor])      state_d = MOVE_DOWN;
                        else if (any_above[cur_floor]) state_d = MOVE_UP;
                        else                           state_d = IDLE;
                    end else begin
                        if (any_above[cur_floor])      state_d = MOVE_UP;
                        else if (any_below[cur_floor]) state_d = MOVE_DOWN;
                        else                           state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with the state.
    always_comb begin
        open_d = (state_d == DOOR_OPEN);
        case (state_d)
            MOVE_UP:   dir_d = DIR_UP;
            MOVE_DOWN: dir_d = DIR_DOWN;
            DOOR_OPEN: dir_d = svc_dir;
            default:   dir_d = DIR_STOP;
        endcase
    end

    assign position  = pos_q;
    assign open      = open_q;
    assign direction = dir_q;

endmodule

// File: tb/tb_elevator_scan.sv
// Directed bench for elevator_scan with a 4-floor and a 6-floor instance.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_elevator_scan;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] button_up4 = '0;
    logic [2:0] button_down4 = '0;
    logic [3:0] button_in4 = '0;
    logic [2:0] position4;
    logic       door4;
    logic [1:0] direction4;
    logic       pending4;

    logic [4:0] button_up6 = '0;
    logic [4:0] button_down6 = '0;
    logic [5:0] button_in6 = '0;
    logic [3:0] position6;
    logic       door6;
    logic [1:0] direction6;
    logic       pending6;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    elevator_scan #(.FLOORS(4), .DOOR_HOLD(2)) u_dut4 (
        .clk         (clk),
        .reset       (reset),
        .button_up   (button_up4),
        .button_down (button_down4),
        .button_in   (button_in4),
        .position    (position4),
        .open        (door4),
        .direction   (direction4),
        .pending     (pending4)
    );

    elevator_scan #(.FLOORS(6), .DOOR_HOLD(2)) u_dut6 (
        .clk         (clk),
        .reset       (reset),
        .button_up   (button_up6),
        .button_down (button_down6),
        .button_in   (button_in6),
        .position    (position6),
        .open        (door6),
        .direction   (direction6),
        .pending     (pending6)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        // A press sampled together with reset must not survive.
        button_in4 = 4'b0100;
        do_reset();
        button_in4 = '0;
        checks++;
        if ({position4, direction4, door4, pending4} !== 7'b000_00_0_0) begin
            fails++;
            $display("FAIL reset: got pos=%0d dir=%b open=%b pend=%b, expected 0 00 0 0",
                     position4, direction4, door4, pending4);
        end
        tick();
        checks++;
        if ({position4, direction4, door4, pending4} !== 7'b000_00_0_0) begin
            fails++;
            $display("FAIL reset_hold: got pos=%0d dir=%b open=%b pend=%b, expected 0 00 0 0",
                     position4, direction4, door4, pending4);
        end
    endtask

    task automatic test_up_trip();
        logic [6:0] exp_v [10];
        logic [6:0] obs;
        exp_v = '{{3'd0, 2'd0, 1'b0, 1'b1}, {3'd0, 2'd1, 1'b0, 1'b1},
                  {3'd1, 2'd1, 1'b0, 1'b1}, {3'd2, 2'd1, 1'b0, 1'b1},
                  {3'd3, 2'd1, 1'b0, 1'b1}, {3'd4, 2'd1, 1'b0, 1'b1},
                  {3'd5, 2'd1, 1'b0, 1'b1}, {3'd6, 2'd1, 1'b1, 1'b0},
                  {3'd6, 2'd1, 1'b1, 1'b0}, {3'd6, 2'd0, 1'b0, 1'b0}};
        do_reset();
        button_in4 = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            tick();
            button_in4 = '0;
            obs = {position4, direction4, door4, pending4};
            checks++;
            if (obs !== exp_v[i]) begin
                fails++;
                $display("FAIL up_trip step %0d: got pos=%0d dir=%b open=%b pend=%b, expected pos=%0d dir=%b open=%b pend=%b",
                         i, obs[6:4], obs[3:2], obs[1], obs[0],
                         exp_v[i][6:4], exp_v[i][3:2], exp_v[i][1], exp_v[i][0]);
            end
        end
    endtask

    task automatic test_pass_and_reverse();
        logic [6:0] exp_v [11];
        logic [6:0] obs;
        exp_v = '{{3'd2, 2'd1, 1'b0, 1'b1}, {3'd3, 2'd1, 1'b0, 1'b1},
                  {3'd4, 2'd1, 1'b0, 1'b1}, {3'd5, 2'd1, 1'b0, 1'b1},
                  {3'd6, 2'd1, 1'b1, 1'b1}, {3'd6, 2'd1, 1'b1, 1'b1},
                  {3'd6, 2'd2, 1'b0, 1'b1}, {3'd5, 2'd2, 1'b0, 1'b1},
                  {3'd4, 2'd2, 1'b1, 1'b0}, {3'd4, 2'd2, 1'b1, 1'b0},
                  {3'd4, 2'd0, 1'b0, 1'b0}};
        do_reset();
        button_in4 = 4'b1000;
        tick();
        button_in4 = '0;
        tick();
        tick();
        checks++;
        if (position4 !== 3'd1 || direction4 !== 2'b01) begin
            fails++;
            $display("FAIL pass_setup: got pos=%0d dir=%b, expected pos=1 dir=01", position4, direction4);
        end
        button_down4 = 3'b010;
        for (int i = 0; i < 11; i++) begin
            tick();
            button_down4 = '0;
            obs = {position4, direction4, door4, pending4};
            checks++;
            if (obs !== exp_v[i]) begin
                fails++;
                $display("FAIL pass_reverse step %0d: got pos=%0d dir=%b open=%b pend=%b, expected pos=%0d dir=%b open=%b pend=%b",
                         i, obs[6:4], obs[3:2], obs[1], obs[0],
                         exp_v[i][6:4], exp_v[i][3:2], exp_v[i][1], exp_v[i][0]);
            end
        end
    endtask

    task automatic test_door_extend();
        logic [6:0] exp_v [13];
        logic [6:0] obs;
        exp_v = '{{3'd2, 2'd1, 1'b1, 1'b1}, {3'd2, 2'd1, 1'b1, 1'b1},
                  {3'd2, 2'd1, 1'b1, 1'b1}, {3'd2, 2'd1, 1'b0, 1'b1},
                  {3'd3, 2'd1, 1'b0, 1'b1}, {3'd4, 2'd1, 1'b0, 1'b1},
                  {3'd5, 2'd1, 1'b0, 1'b1}, {3'd6, 2'd1, 1'b1, 1'b0},
                  {3'd6, 2'd1, 1'b1, 1'b0}, {3'd6, 2'd0, 1'b0, 1'b0},
                  {3'd6, 2'd0, 1'b0, 1'b0}, {3'd6, 2'd0, 1'b0, 1'b0},
                  {3'd6, 2'd0, 1'b0, 1'b0}};
        do_reset();
        button_up4 = 3'b010;
        button_in4 = 4'b1000;
        tick();
        button_up4 = '0;
        button_in4 = '0;
        tick();
        tick();
        for (int i = 0; i < 13; i++) begin
            // Repeat the up call at floor 1 so it is sampled at the edge opening the second door cycle.
            button_up4 = (i == 1) ? 3'b010 : 3'b000;
            tick();
            obs = {position4, direction4, door4, pending4};
            checks++;
            if (obs !== exp_v[i]) begin
                fails++;
                $display("FAIL door_extend step %0d: got pos=%0d dir=%b open=%b pend=%b, expected pos=%0d dir=%b open=%b pend=%b",
                         i, obs[6:4], obs[3:2], obs[1], obs[0],
                         exp_v[i][6:4], exp_v[i][3:2], exp_v[i][1], exp_v[i][0]);
            end
        end
        button_up4 = '0;
    endtask

    task automatic test_reset_midmove();
        do_reset();
        button_in4   = 4'b1000;
        button_down4 = 3'b001;
        tick();
        button_in4   = '0;
        button_down4 = '0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (position4 !== 3'd3 || direction4 !== 2'b01 || pending4 !== 1'b1) begin
            fails++;
            $display("FAIL midmove_setup: got pos=%0d dir=%b pend=%b, expected pos=3 dir=01 pend=1",
                     position4, direction4, pending4);
        end
        do_reset();
        checks++;
        if ({position4, direction4, door4, pending4} !== 7'b000_00_0_0) begin
            fails++;
            $display("FAIL midmove_reset: got pos=%0d dir=%b open=%b pend=%b, expected 0 00 0 0",
                     position4, direction4, door4, pending4);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({position4, direction4, door4, pending4} !== 7'b000_00_0_0) begin
                fails++;
                $display("FAIL midmove_after %0d: got pos=%0d dir=%b open=%b pend=%b, expected 0 00 0 0",
                         i, position4, direction4, door4, pending4);
            end
        end
    endtask

    task automatic test_idle_open();
        logic [6:0] exp_v [4];
        logic [6:0] obs;
        exp_v = '{{3'd0, 2'd0, 1'b0, 1'b1}, {3'd0, 2'd0, 1'b1, 1'b0},
                  {3'd0, 2'd0, 1'b1, 1'b0}, {3'd0, 2'd0, 1'b0, 1'b0}};
        do_reset();
        button_up4 = 3'b001;
        for (int i = 0; i < 4; i++) begin
            tick();
            button_up4 = '0;
            obs = {position4, direction4, door4, pending4};
            checks++;
            if (obs !== exp_v[i]) begin
                fails++;
                $display("FAIL idle_open step %0d: got pos=%0d dir=%b open=%b pend=%b, expected pos=%0d dir=%b open=%b pend=%b",
                         i, obs[6:4], obs[3:2], obs[1], obs[0],
                         exp_v[i][6:4], exp_v[i][3:2], exp_v[i][1], exp_v[i][0]);
            end
        end
    endtask

    task automatic test_six_floors();
        int  exp_pos;
        logic exp_open;
        do_reset();
        button_in6 = 6'b100000;
        for (int k = 0; k < 16; k++) begin
            tick();
            button_in6 = '0;
            exp_pos  = (k <= 1) ? 0 : ((k - 1 > 10) ? 10 : k - 1);
            exp_open = (k == 11 || k == 12);
            checks++;
            if (position6 !== 4'(exp_pos) || door6 !== exp_open) begin
                fails++;
                $display("FAIL six_floors step %0d: got pos=%0d open=%b, expected pos=%0d open=%b",
                         k, position6, door6, exp_pos, exp_open);
            end
        end
        checks++;
        if (direction6 !== 2'b00 || pending6 !== 1'b0) begin
            fails++;
            $display("FAIL six_floors_end: got dir=%b pend=%b, expected dir=00 pend=0", direction6, pending6);
        end
    endtask

    initial begin
        test_reset();
        test_up_trip();
        test_pass_and_reverse();
        test_door_extend();
        test_reset_midmove();
        test_idle_open();
        test_six_floors();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
